// File: rtl/vec_issue_queue.sv
// vec_issue_queue: small FIFO between the scalar core's vector-instruction
// outputs and the vector coprocessor. Entries hold {instruction, scalar
// operand}; non-vector opcodes are rejected at enqueue and flagged on `drop`.
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high. Once out_valid is asserted it holds, together with its data,
// until out_ready accepts it. in_ready, count and busy come from the
// registered pointers only, so nothing combinational runs from in_valid or
// out_ready to them.
module vec_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WORD_WIDTH-1:0]      in_instr,
    input  logic [WORD_WIDTH-1:0]      in_xdata,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WORD_WIDTH-1:0]      out_instr,
    output logic [WORD_WIDTH-1:0]      out_xdata,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int EW = 2 * WORD_WIDTH;

    localparam logic [6:0] OPC_OP_V  = 7'b1010111;
    localparam logic [6:0] OPC_VLOAD = 7'b0000111;
    localparam logic [6:0] OPC_VSTOR = 7'b0100111;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          drop_q, drop_d;

    logic          empty;
    logic          full;
    logic          opc_ok;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Occupancy flags: the extra pointer MSB tells full from empty when the
    // index bits coincide.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    end

    // Opcode filter and transfer qualification.
    always_comb begin
        opc_ok = (in_instr[6:0] == OPC_OP_V) ||
                 (in_instr[6:0] == OPC_VLOAD) ||
                 (in_instr[6:0] == OPC_VSTOR);
        push   = in_valid && !full && opc_ok;
        pop    = !empty && out_ready;
    end

    // Next-state for pointers and the drop flag; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = in_valid && !full && !opc_ok;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            drop_d   = 1'b0;
        end
    end

    // Pointer and drop-flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage; contents survive flush and reset, only pointers matter.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q[IW-1:0]] <= {in_instr, in_xdata};
        end
    end

    // First-word-fall-through head read, forced to zero while empty.
    always_comb begin
        head      = mem_q[rd_ptr_q[IW-1:0]];
        out_valid = !empty;
        out_instr = empty ? '0 : head[EW-1:WORD_WIDTH];
        out_xdata = empty ? '0 : head[WORD_WIDTH-1:0];
        in_ready  = !full;
        count     = wr_ptr_q - rd_ptr_q;
        busy      = !empty;
        drop      = drop_q;
    end

endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed bench for vec_issue_queue: reset, single push/pop, fill/drain with
// pointer wrap, opcode drop, flush priority, streaming order, async reset.
module tb_vec_issue_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_xdata;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_xdata;
    logic        out_ready;
    logic        flush;
    logic        drop;
    logic [2:0]  count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    vec_issue_queue #(.DEPTH(4), .WORD_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_xdata  (in_xdata),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_xdata (out_xdata),
        .out_ready (out_ready),
        .flush     (flush),
        .drop      (drop),
        .count     (count),
        .busy      (busy)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] words [4];
        logic [31:0] xd;
        logic [63:0] e;

        words[0] = 32'h0220_0057;  // OP-V
        words[1] = 32'h0000_5007;  // vector load
        words[2] = 32'h0000_6027;  // vector store
        words[3] = 32'h0C20_1057;  // OP-V

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_xdata  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // reset / idle
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_xdata", out_xdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);

        // single push, visible next cycle, then pop
        in_valid = 1'b1;
        in_instr = 32'h0200_7057;
        in_xdata = 32'h0000_0010;
        check("single_no_bypass", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_instr", out_instr, 32'h0200_7057);
        check("single_xdata", out_xdata, 32'h0000_0010);
        check("single_count", 32'(count), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_empty_valid", 32'(out_valid), 32'd0);
        check("single_empty_count", 32'(count), 32'd0);
        check("single_empty_instr", out_instr, 32'd0);

        // two fills; the second wraps both pointers
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_instr = words[i] ^ (32'(pass) << 20);
                in_xdata = 32'h1111_0000 + 32'(pass * 16 + i);
                step();
                check("fill_head_instr", out_instr, words[0] ^ (32'(pass) << 20));
                check("fill_count", 32'(count), 32'(i + 1));
            end
            check("full_in_ready", 32'(in_ready), 32'd0);
            // fifth word while full: ignored, no drop even if non-vector
            in_instr = 32'h0300_0057;
            step();
            check("full_ignore_count", 32'(count), 32'd4);
            check("full_ignore_drop", 32'(drop), 32'd0);
            in_instr = 32'h0000_0013;
            step();
            in_valid = 1'b0;
            check("full_nonvec_drop", 32'(drop), 32'd0);
            check("full_hold_instr", out_instr, words[0] ^ (32'(pass) << 20));
            // drain in order
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                check("drain_valid", 32'(out_valid), 32'd1);
                check("drain_instr", out_instr, words[i] ^ (32'(pass) << 20));
                check("drain_xdata", out_xdata, 32'h1111_0000 + 32'(pass * 16 + i));
                step();
                if (i == 0) check("drain_ready_after_pop", 32'(in_ready), 32'd1);
            end
            out_ready = 1'b0;
            check("drain_empty", 32'(out_valid), 32'd0);
            check("drain_count", 32'(count), 32'd0);
        end

        // rejected opcode: drop for exactly one cycle, nothing stored
        in_valid = 1'b1;
        in_instr = 32'h0000_0013;
        in_xdata = 32'hDEAD_BEEF;
        check("drop_not_early", 32'(drop), 32'd0);
        step();
        in_valid = 1'b0;
        check("drop_pulse", 32'(drop), 32'd1);
        check("drop_count", 32'(count), 32'd0);
        check("drop_out_valid", 32'(out_valid), 32'd0);
        step();
        check("drop_clear", 32'(drop), 32'd0);

        // flush beats simultaneous push and pop at count 2
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = words[i];
            in_xdata = 32'(i);
            step();
        end
        check("pre_flush_count", 32'(count), 32'd2);
        in_instr  = words[2];
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_instr", out_instr, 32'd0);
        // flush also suppresses a drop
        in_valid = 1'b1;
        in_instr = 32'h0000_0013;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_drop", 32'(drop), 32'd0);

        // streaming at count 2: simultaneous push/pop, order preserved
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h0400_0057 + (32'(i) << 15);
            in_xdata = 32'hA000_0000 + 32'(i);
            exp_q.push_back({in_instr, in_xdata});
            step();
        end
        for (int k = 2; k < 12; k++) begin
            in_valid  = 1'b1;
            in_instr  = 32'h0400_0057 + (32'(k) << 15);
            in_xdata  = 32'hA000_0000 + 32'(k);
            out_ready = 1'b1;
            e = exp_q.pop_front();
            check("stream_instr", out_instr, e[63:32]);
            check("stream_xdata", out_xdata, e[31:0]);
            exp_q.push_back({in_instr, in_xdata});
            step();
            check("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            check("stream_tail_instr", out_instr, e[63:32]);
            step();
        end
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // asynchronous reset mid-operation
        in_valid = 1'b1;
        in_instr = words[1];
        in_xdata = 32'h5555_5555;
        step();
        in_valid = 1'b0;
        check("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        xd = out_xdata;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_xdata", xd, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        check("post_arst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_issue_queue.md
# vec_issue_queue

Buffers vector instructions issued by the scalar RV32IMC core toward the vector coprocessor. It sits directly downstream of the core's `v_instr` / `xreg_out` outputs and decouples scalar issue from coprocessor acceptance with a small FIFO. Each entry holds the instruction word and its scalar operand. Instruction words whose opcode is not a vector opcode are filtered out at enqueue.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries; must be a power of 2, at least 2.
- `WORD_WIDTH`, 32: instruction and scalar operand width.

Ports:
- `clk`  in  1  system clock (`CLK_BUF` domain).
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  core presents a candidate vector instruction.
- `in_instr`  in  WORD_WIDTH  instruction word (`v_instr`).
- `in_xdata`  in  WORD_WIDTH  scalar operand read for this instruction (`xreg_out`).
- `in_ready`  out  1  queue can accept; equals not-full.
- `out_valid`  out  1  head entry is valid.
- `out_instr`  out  WORD_WIDTH  head instruction word.
- `out_xdata`  out  WORD_WIDTH  head scalar operand.
- `out_ready`  in  1  coprocessor accepts the head entry.
- `flush`  in  1  discard all entries (core pipeline flush).
- `drop`  out  1  one-cycle pulse: an `in_valid` word was rejected by the opcode filter.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `busy`  out  1  `count != 0`.

## Operation
- Storage: `DEPTH` x (2·WORD_WIDTH) register array. Write and read pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
- Empty: pointers are equal. Full: index bits are equal and the MSBs differ.
- Opcode filter: `in_instr[6:0]` is accepted only if it is 7'b1010111 (OP-V), 7'b0000111 (vector load) or 7'b0100111 (vector store).
- Push when `in_valid & in_ready & opcode accepted`: write `{in_instr, in_xdata}` at the write pointer, then increment it.
- Drop when `in_valid & in_ready & opcode rejected`: no write. `drop` goes to 1 on the next cycle for one cycle.
- `in_valid` while full: nothing happens. No drop is flagged. The core is responsible for holding the word.
- Pop when `out_valid & out_ready`: increment the read pointer.
- `out_instr` / `out_xdata` are combinational reads at the read pointer (first-word-fall-through). When empty they are held at 0.
- Simultaneous push and pop (not full, not empty): both occur. `count` is unchanged.
- Push into an empty queue has no bypass. The entry becomes visible on the next cycle.
- Pop from a full queue does not raise `in_ready` in the same cycle. `in_ready` is the registered not-full state.
- `flush`: both pointers clear to 0 on the next edge and `drop` clears. Flush beats any push or pop in the same cycle. Array contents are not cleared.
- State machine: none beyond the pointers. `drop` is a registered flag.

## Timing
- Reset (async assert, released at a clock edge): pointers = 0, `drop` = 0. Resulting outputs: `out_valid` = 0, `out_instr` = 0, `out_xdata` = 0, `in_ready` = 1, `count` = 0, `busy` = 0.
- Latency from push to `out_valid` = 1 is one cycle.
- Minimum residency of an entry is one cycle.
- Throughput is one push and one pop per cycle.
- `out_valid`, `out_instr` and `out_xdata` are stable while `out_ready` = 0. This follows the valid/ready rule: once asserted, valid holds until accepted.
- `in_ready`, `count` and `busy` are registered. They depend only on the pointers, with no combinational path from `in_valid` or `out_ready`.
- `drop` is asserted exactly one cycle after the rejected `in_valid` cycle.
- Reset asserted mid-operation: all entries are lost immediately and the outputs take their reset values asynchronously.

## Test plan
- Reset, then idle: `in_ready` = 1, `out_valid` = 0, `count` = 0, `out_instr` = 0.
- Push 0x0200_7057 with `in_xdata` = 0x0000_0010, `out_ready` = 0. Next cycle: `out_valid` = 1, `out_instr` = 0x0200_7057, `out_xdata` = 0x10, `count` = 1. Raise `out_ready`: empty the following cycle.
- Push 4 distinct vector words back-to-back with `out_ready` = 0. After the 4th: `count` = 4, `in_ready` = 0. A 5th `in_valid` is ignored with no `drop`. Drain with `out_ready` = 1: the 4 words appear in order, one per cycle, and pointers wrap correctly on a second fill.
- Push 0x0000_0013 (ADDI): no entry is written, `drop` = 1 for exactly one cycle, `count` stays 0.
- Hold `count` = 2 while asserting push, pop and `flush` together: next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1.
- Hold `count` = 2 with simultaneous push and pop for 10 cycles of streaming: `count` stays 2, and the output order matches the input order.
